// File: rtl/prim_clock_mux_sel_seq.sv
// -----------------------------------------------------------------------------
// prim_clock_mux_sel_seq
//
// Owns the select line of a two-input glitch-prone clock mux. Switch requests
// arrive as a 4-phase req/ack handshake that is asynchronous to the always-on
// reference clock. For a real switch the sequencer first gates the mux output
// (clk_en_o low), lets both sources settle, flips the select, settles again,
// then re-enables the gate and acknowledges. The select therefore never moves
// while the gated output clock is enabled.
//
// Ports
//   clk_i         always-on reference clock
//   rst_i         asynchronous reset, active-high
//   req_i         switch request (level, asynchronous to clk_i)
//   sel_target_i  requested select, sampled when the switch is started
//   ack_o         request done; held until the synchronized request drops
//   busy_o        high whenever the sequencer is not idle
//   sel_o         registered select to the clock mux
//   clk_en_o      registered enable to the clock gate after the mux
//   err_o         one-cycle pulse: request withdrawn before it was acked
// -----------------------------------------------------------------------------
module prim_clock_mux_sel_seq #(
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned SyncStages   = 2,
    parameter bit          ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic sel_target_i,
    output logic ack_o,
    output logic busy_o,
    output logic sel_o,
    output logic clk_en_o,
    output logic err_o
);

    localparam int unsigned CntW = $clog2(SettleCycles + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GATE_WAIT = 2'd1,
        ON_WAIT   = 2'd2,
        ACK       = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] req_sync_q;
    logic                  req_s;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  cnt_zero_s;
    logic                  tgt_q, tgt_d;
    logic                  drop_q, drop_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  sel_q, sel_d;
    logic                  en_q, en_d;
    logic                  err_q, err_d;

    // Request synchronizer: req_i is asynchronous, only the last flop is used.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SyncStages-2:0], req_i};
        end
    end

    assign req_s      = req_sync_q[SyncStages-1];
    assign cnt_zero_s = (cnt_q == {CntW{1'b0}});

    // State register plus all registered datapath and outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= {CntW{1'b0}};
            tgt_q   <= ResetSel;
            drop_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= ResetSel;
            en_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            drop_q  <= drop_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (sel_target_i == sel_q) begin
                        state_d = ACK;
                    end else begin
                        state_d = GATE_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GATE_WAIT: begin
                if (cnt_zero_s) begin
                    state_d = ON_WAIT;
                end else begin
                    state_d = GATE_WAIT;
                end
            end
            ON_WAIT: begin
                if (cnt_zero_s) begin
                    state_d = ACK;
                end else begin
                    state_d = ON_WAIT;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath next values. Outputs are registered so that the
    // gate enable and select are glitch-free at the mux.
    always_comb begin
        cnt_d  = cnt_q;
        tgt_d  = tgt_q;
        drop_d = drop_q;
        ack_d  = ack_q;
        sel_d  = sel_q;
        en_d   = en_q;
        err_d  = 1'b0;
        // busy follows the state being entered, so it rises on E0 itself
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (req_s) begin
                    if (sel_target_i == sel_q) begin
                        ack_d = 1'b1;
                    end else begin
                        // gate first; target is frozen here so later changes are ignored
                        en_d  = 1'b0;
                        tgt_d = sel_target_i;
                        cnt_d = CntLoad;
                    end
                end else begin
                    ack_d = 1'b0;
                end
            end
            GATE_WAIT: begin
                // a withdrawn request does not abort the switch, it is only flagged
                if (!req_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (cnt_zero_s) begin
                    sel_d = tgt_q;
                    cnt_d = CntLoad;
                end else begin
                    cnt_d = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            ON_WAIT: begin
                if (cnt_zero_s) begin
                    en_d   = 1'b1;
                    ack_d  = 1'b1;
                    err_d  = drop_q | ~req_s;
                    drop_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
                    drop_d = drop_q | ~req_s;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d = 1'b0;
                en_d  = 1'b1;
            end
        endcase
    end

    assign ack_o    = ack_q;
    assign busy_o   = busy_q;
    assign sel_o    = sel_q;
    assign clk_en_o = en_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_prim_clock_mux_sel_seq.sv
// -----------------------------------------------------------------------------
// Bench for prim_clock_mux_sel_seq: directed handshake scenarios followed by
// randomized requests, drops and resets, all compared every cycle against a
// timestamp-based reference model of the switch protocol.
// -----------------------------------------------------------------------------
module tb_prim_clock_mux_sel_seq;

    localparam int S    = 4;
    localparam int SS   = 2;
    localparam bit RSEL = 1'b0;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic req_i = 1'b0;
    logic sel_target_i = 1'b0;
    logic ack_o, busy_o, sel_o, clk_en_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    prim_clock_mux_sel_seq #(
        .SettleCycles (S),
        .SyncStages   (SS),
        .ResetSel     (RSEL)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .sel_target_i (sel_target_i),
        .ack_o        (ack_o),
        .busy_o       (busy_o),
        .sel_o        (sel_o),
        .clk_en_o     (clk_en_o),
        .err_o        (err_o)
    );

    // Reference model: protocol phases with absolute edge timestamps.
    localparam int MAXC   = 8192;
    localparam int M_IDLE = 0;
    localparam int M_SW   = 1;
    localparam int M_ACK  = 2;

    bit req_hist [MAXC];
    int cyc      = 0;
    int last_rst = 0;
    int m_mode   = M_IDLE;
    int m_e0     = 0;
    bit m_sel = RSEL, m_en = 1'b1, m_ack = 1'b0, m_busy = 1'b0, m_err = 1'b0;
    bit m_tgt = 1'b0, m_drop = 1'b0;

    // Model update on each reference-clock edge.
    always @(posedge clk_i) begin : model
        bit rs;
        cyc = cyc + 1;
        if (cyc < MAXC) req_hist[cyc] = req_i;
        if (rst_i) begin
            last_rst = cyc;
            m_mode = M_IDLE; m_sel = RSEL; m_en = 1'b1; m_ack = 1'b0;
            m_busy = 1'b0; m_err = 1'b0; m_drop = 1'b0;
        end else begin
            // request seen by the sequencer = req_i as sampled SS edges ago,
            // provided the synchronizer was not cleared since then
            rs = (cyc - SS > last_rst && cyc < MAXC) ? req_hist[cyc - SS] : 1'b0;
            m_err = 1'b0;
            if (m_mode == M_IDLE) begin
                if (rs) begin
                    if (sel_target_i == m_sel) begin
                        m_ack = 1'b1; m_mode = M_ACK;
                    end else begin
                        m_e0 = cyc; m_tgt = sel_target_i; m_en = 1'b0;
                        m_drop = 1'b0; m_mode = M_SW;
                    end
                end
            end else if (m_mode == M_SW) begin
                if (!rs) m_drop = 1'b1;
                if (cyc == m_e0 + S) m_sel = m_tgt;
                if (cyc == m_e0 + 2 * S) begin
                    m_en = 1'b1; m_ack = 1'b1; m_err = m_drop; m_mode = M_ACK;
                end
            end else begin
                if (!rs) begin
                    m_ack = 1'b0; m_mode = M_IDLE;
                end
            end
            m_busy = (m_mode != M_IDLE);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset_now(input string tag);
        check_eq({tag, "_sel"},  sel_o,    RSEL);
        check_eq({tag, "_en"},   clk_en_o, 1);
        check_eq({tag, "_ack"},  ack_o,    0);
        check_eq({tag, "_busy"}, busy_o,   0);
        check_eq({tag, "_err"},  err_o,    0);
    endtask

    // One cycle: compare at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        if (rst_i) begin
            chk_reset_now("cyc_rst");
        end else begin
            check_eq("cyc_sel",  sel_o,    m_sel);
            check_eq("cyc_en",   clk_en_o, m_en);
            check_eq("cyc_ack",  ack_o,    m_ack);
            check_eq("cyc_busy", busy_o,   m_busy);
            check_eq("cyc_err",  err_o,    m_err);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Complete well-behaved 4-phase request; checks the handshake timing.
    task automatic full_req(input bit tgt);
        int n, low, i_low, i_sel;
        bit same;
        same = (tgt == m_sel);
        sel_target_i = tgt;
        req_i = 1'b1;
        n = 0; low = 0; i_low = -1; i_sel = -1;
        while (!ack_o && n < 4 * S + SS + 10) begin
            tick();
            n++;
            if (!clk_en_o) begin
                low++;
                if (i_low < 0) i_low = n;
            end
            if (sel_o == tgt && i_sel < 0) i_sel = n;
        end
        check_eq("req_ack_seen", ack_o, 1);
        check_eq("req_ack_lat", n, same ? SS + 1 : SS + 1 + 2 * S);
        check_eq("req_en_low", low, same ? 0 : 2 * S);
        check_eq("req_ack_en", clk_en_o, 1);
        check_eq("req_sel_after", sel_o, tgt);
        if (!same) check_eq("req_sel_delay", i_sel - i_low, S);
        req_i = 1'b0;
        n = 0;
        while (ack_o && n < SS + 10) begin
            tick();
            n++;
        end
        check_eq("drop_ack_lat", n, SS + 1);
        check_eq("drop_busy", busy_o, 0);
    endtask

    initial begin
        int n, n_err, n_ack;
        // 1: reset held for five cycles
        repeat (5) tick();
        chk_reset_now("t1");
        rst_i = 1'b0;
        repeat (2) tick();

        // 2: real switch 0 -> 1
        full_req(1'b1);
        // 3: request for the current select is acked without gating
        full_req(1'b1);
        // 4: switch back to 0
        full_req(1'b0);

        // 5: request withdrawn two cycles after E0
        sel_target_i = 1'b1;
        req_i = 1'b1;
        repeat (SS + 1) tick();
        check_eq("t5_gated", clk_en_o, 0);
        repeat (2) tick();
        req_i = 1'b0;
        n_err = 0; n_ack = 0;
        repeat (3 * S + SS + 6) begin
            tick();
            if (err_o) n_err++;
            if (ack_o) n_ack++;
        end
        check_eq("t5_err_width", n_err, 1);
        check_eq("t5_ack_width", n_ack, 1);
        check_eq("t5_sel", sel_o, 1);
        check_eq("t5_busy", busy_o, 0);

        // 6: asynchronous reset in the middle of GATE_WAIT
        sel_target_i = 1'b0;
        req_i = 1'b1;
        repeat (SS + 3) tick();
        check_eq("t6_gated", clk_en_o, 0);
        #2 rst_i = 1'b1;
        #1 chk_reset_now("t6_async");
        req_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (3) tick();
        full_req(1'b1);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int kind, d;
            bit tgt;
            kind = int'($urandom_range(0, 9));
            tgt  = 1'($urandom_range(0, 1));
            if (kind < 6) begin
                full_req(tgt);
            end else if (kind < 9) begin
                d = int'($urandom_range(1, 2 * S + 3));
                sel_target_i = tgt;
                req_i = 1'b1;
                repeat (d) tick();
                req_i = 1'b0;
                sel_target_i = 1'($urandom_range(0, 1));
                repeat (SS + 2) tick();
                n = 0;
                while ((busy_o || ack_o) && n < 6 * S + SS + 10) begin
                    tick();
                    n++;
                end
                check_eq("rnd_drop_idle", busy_o | ack_o, 0);
            end else begin
                sel_target_i = tgt;
                req_i = 1'b1;
                repeat ($urandom_range(0, 2 * S + SS)) tick();
                #2 rst_i = 1'b1;
                #1 chk_reset_now("rnd_async");
                req_i = 1'b0;
                repeat (2) tick();
                rst_i = 1'b0;
                tick();
            end
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
